// File: rtl/registro_id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: widths, ALU op classes
// and the control bundle that a bubble or flush clears as one field.
package pkg_segmentacion;

    localparam int unsigned ANCHO_DATO = 32;
    localparam int unsigned ANCHO_REG  = 5;

    // ALU operation class produced by the decoder
    typedef enum logic [1:0] {
        ALU_MEM    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10
    } alu_op_e;

    // Control bits that travel ID -> EX; zeroing this struct makes a bubble
    typedef struct packed {
        logic    salto;
        logic    branch;
        logic    mem_leer;
        logic    mem_a_reg;
        logic    mem_escribir;
        logic    alu_fuente;
        logic    reg_escribir;
        alu_op_e alu_operacion;
    } control_t;

    // The rt field is a real source operand for R-type, stores and branches
    function automatic logic usa_rt(input logic alu_fuente,
                                    input logic mem_escribir,
                                    input logic branch);
        return !alu_fuente | mem_escribir | branch;
    endfunction

endpackage

// File: rtl/registro_id_ex_if.sv
// ID/EX bundle: decode-side fields in, execute-side registered copies out,
// plus the hazard freeze signals returned towards fetch.
interface registro_id_ex_if #(
    parameter int unsigned ANCHO_DATO = pkg_segmentacion::ANCHO_DATO,
    parameter int unsigned ANCHO_REG  = pkg_segmentacion::ANCHO_REG
);
    logic                  salto_id, branch_id, mem_leer_id, mem_a_reg_id;
    logic                  mem_escribir_id, alu_fuente_id, reg_escribir_id, destino_reg_id;
    logic [1:0]            alu_operacion_id;
    logic [ANCHO_DATO-1:0] dr1_id, dr2_id, ext_id, pc_plus4_id, jump_address_id;
    logic [5:0]            funct_id;
    logic [ANCHO_REG-1:0]  rs_id, rt_id, rd_id;
    logic                  valido_id;
    logic                  vaciar;
    logic                  detener;

    logic                  salto_ex, branch_ex, mem_leer_ex, mem_a_reg_ex;
    logic                  mem_escribir_ex, alu_fuente_ex, reg_escribir_ex, destino_reg_ex;
    logic [1:0]            alu_operacion_ex;
    logic [ANCHO_DATO-1:0] dr1_ex, dr2_ex, ext_ex, pc_plus4_ex, jump_address_ex;
    logic [5:0]            funct_ex;
    logic [ANCHO_REG-1:0]  rs_ex, rt_ex, rd_ex;
    logic                  valido_ex;
    logic [ANCHO_REG-1:0]  reg_dest_ex;
    logic                  pc_escribir;
    logic                  ifid_escribir;

    modport master (
        output salto_id, branch_id, mem_leer_id, mem_a_reg_id, mem_escribir_id,
               alu_fuente_id, reg_escribir_id, destino_reg_id, alu_operacion_id,
               dr1_id, dr2_id, ext_id, pc_plus4_id, jump_address_id, funct_id,
               rs_id, rt_id, rd_id, valido_id, vaciar, detener,
        input  salto_ex, branch_ex, mem_leer_ex, mem_a_reg_ex, mem_escribir_ex,
               alu_fuente_ex, reg_escribir_ex, destino_reg_ex, alu_operacion_ex,
               dr1_ex, dr2_ex, ext_ex, pc_plus4_ex, jump_address_ex, funct_ex,
               rs_ex, rt_ex, rd_ex, valido_ex, reg_dest_ex, pc_escribir, ifid_escribir
    );

    modport slave (
        input  salto_id, branch_id, mem_leer_id, mem_a_reg_id, mem_escribir_id,
               alu_fuente_id, reg_escribir_id, destino_reg_id, alu_operacion_id,
               dr1_id, dr2_id, ext_id, pc_plus4_id, jump_address_id, funct_id,
               rs_id, rt_id, rd_id, valido_id, vaciar, detener,
        output salto_ex, branch_ex, mem_leer_ex, mem_a_reg_ex, mem_escribir_ex,
               alu_fuente_ex, reg_escribir_ex, destino_reg_ex, alu_operacion_ex,
               dr1_ex, dr2_ex, ext_ex, pc_plus4_ex, jump_address_ex, funct_ex,
               rs_ex, rt_ex, rd_ex, valido_ex, reg_dest_ex, pc_escribir, ifid_escribir
    );

endinterface

// File: rtl/registro_id_ex_deteccion_riesgos.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
// Purely combinational; a flush overrides the freeze.
module deteccion_riesgos
    import pkg_segmentacion::*;
#(
    parameter int unsigned ANCHO_REG = pkg_segmentacion::ANCHO_REG
) (
    input  logic                 valido_ex,
    input  logic                 mem_leer_ex,
    input  logic [ANCHO_REG-1:0] reg_dest_ex,
    input  logic                 valido_id,
    input  logic [ANCHO_REG-1:0] rs_id,
    input  logic [ANCHO_REG-1:0] rt_id,
    input  logic                 alu_fuente_id,
    input  logic                 mem_escribir_id,
    input  logic                 branch_id,
    input  logic                 vaciar,
    output logic                 riesgo,
    output logic                 pc_escribir,
    output logic                 ifid_escribir
);

    logic lee_rt;
    logic coincide;

    // Hazard when a valid load in EX writes a non-zero register that ID reads
    always_comb begin
        lee_rt        = usa_rt(alu_fuente_id, mem_escribir_id, branch_id);
        coincide      = (reg_dest_ex == rs_id) | (lee_rt & (reg_dest_ex == rt_id));
        riesgo        = valido_ex & mem_leer_ex & valido_id & (reg_dest_ex != '0) & coincide;
        pc_escribir   = !(riesgo & !vaciar);
        ifid_escribir = !(riesgo & !vaciar);
    end

endmodule

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, flush and stall.
// Optional performance counters enabled by defining CONTADORES_RENDIMIENTO_EN.
module registro_id_ex
    import pkg_segmentacion::*;
#(
    parameter int unsigned ANCHO_DATO = pkg_segmentacion::ANCHO_DATO,
    parameter int unsigned ANCHO_REG  = pkg_segmentacion::ANCHO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    registro_id_ex_if.slave   bus
`ifdef CONTADORES_RENDIMIENTO_EN
    ,
    output logic [31:0]       cuenta_burbujas,
    output logic [31:0]       cuenta_vaciados
`endif
);

    control_t              ctrl_id;
    control_t              ctrl_ex;
    logic                  destino_reg_q;
    logic [ANCHO_DATO-1:0] dr1_q, dr2_q, ext_q, pc_plus4_q, jump_address_q;
    logic [5:0]            funct_q;
    logic [ANCHO_REG-1:0]  rs_q, rt_q, rd_q, reg_dest_q;
    logic                  valido_q;
    logic [ANCHO_REG-1:0]  reg_dest_id;
    logic                  riesgo;
    logic                  captura;
    logic                  burbuja;

    assign ctrl_id = '{
        salto:         bus.salto_id,
        branch:        bus.branch_id,
        mem_leer:      bus.mem_leer_id,
        mem_a_reg:     bus.mem_a_reg_id,
        mem_escribir:  bus.mem_escribir_id,
        alu_fuente:    bus.alu_fuente_id,
        reg_escribir:  bus.reg_escribir_id,
        alu_operacion: alu_op_e'(bus.alu_operacion_id)
    };

    assign reg_dest_id = bus.destino_reg_id ? bus.rd_id : bus.rt_id;

    deteccion_riesgos #(
        .ANCHO_REG (ANCHO_REG)
    ) u_deteccion_riesgos (
        .valido_ex       (valido_q),
        .mem_leer_ex     (ctrl_ex.mem_leer),
        .reg_dest_ex     (reg_dest_q),
        .valido_id       (bus.valido_id),
        .rs_id           (bus.rs_id),
        .rt_id           (bus.rt_id),
        .alu_fuente_id   (bus.alu_fuente_id),
        .mem_escribir_id (bus.mem_escribir_id),
        .branch_id       (bus.branch_id),
        .vaciar          (bus.vaciar),
        .riesgo          (riesgo),
        .pc_escribir     (bus.pc_escribir),
        .ifid_escribir   (bus.ifid_escribir)
    );

    // Priority vaciar > detener > riesgo folded into two enables: the register
    // loads unless stalled (a flush still loads), and loads a bubble on flush
    // or on an un-stalled hazard.
    assign captura = bus.vaciar | !bus.detener;
    assign burbuja = bus.vaciar | (!bus.detener & riesgo);

    // Pipeline register: data always follows ID on capture, control/valid zeroed on bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ex        <= '0;
            destino_reg_q  <= 1'b0;
            dr1_q          <= '0;
            dr2_q          <= '0;
            ext_q          <= '0;
            pc_plus4_q     <= '0;
            jump_address_q <= '0;
            funct_q        <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            reg_dest_q     <= '0;
            valido_q       <= 1'b0;
        end else if (captura) begin
            ctrl_ex        <= burbuja ? control_t'('0) : ctrl_id;
            valido_q       <= !burbuja & bus.valido_id;
            destino_reg_q  <= bus.destino_reg_id;
            dr1_q          <= bus.dr1_id;
            dr2_q          <= bus.dr2_id;
            ext_q          <= bus.ext_id;
            pc_plus4_q     <= bus.pc_plus4_id;
            jump_address_q <= bus.jump_address_id;
            funct_q        <= bus.funct_id;
            rs_q           <= bus.rs_id;
            rt_q           <= bus.rt_id;
            rd_q           <= bus.rd_id;
            reg_dest_q     <= reg_dest_id;
        end
    end

    assign bus.salto_ex         = ctrl_ex.salto;
    assign bus.branch_ex        = ctrl_ex.branch;
    assign bus.mem_leer_ex      = ctrl_ex.mem_leer;
    assign bus.mem_a_reg_ex     = ctrl_ex.mem_a_reg;
    assign bus.mem_escribir_ex  = ctrl_ex.mem_escribir;
    assign bus.alu_fuente_ex    = ctrl_ex.alu_fuente;
    assign bus.reg_escribir_ex  = ctrl_ex.reg_escribir;
    assign bus.alu_operacion_ex = ctrl_ex.alu_operacion;
    assign bus.destino_reg_ex   = destino_reg_q;
    assign bus.dr1_ex           = dr1_q;
    assign bus.dr2_ex           = dr2_q;
    assign bus.ext_ex           = ext_q;
    assign bus.pc_plus4_ex      = pc_plus4_q;
    assign bus.jump_address_ex  = jump_address_q;
    assign bus.funct_ex         = funct_q;
    assign bus.rs_ex            = rs_q;
    assign bus.rt_ex            = rt_q;
    assign bus.rd_ex            = rd_q;
    assign bus.reg_dest_ex      = reg_dest_q;
    assign bus.valido_ex        = valido_q;

`ifdef CONTADORES_RENDIMIENTO_EN
    // Bubble counter ignores stalled edges; flush counter counts regardless of stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_burbujas <= '0;
            cuenta_vaciados <= '0;
        end else begin
            if (bus.vaciar)
                cuenta_vaciados <= cuenta_vaciados + 32'd1;
            else if (!bus.detener && riesgo)
                cuenta_burbujas <= cuenta_burbujas + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_registro_id_ex.sv
// Self-checking bench for registro_id_ex: directed hazard table, hand-written
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_registro_id_ex;

    typedef struct packed {
        logic        salto;
        logic        branch;
        logic        mem_leer;
        logic        mem_a_reg;
        logic        mem_escribir;
        logic        alu_fuente;
        logic        reg_escribir;
        logic [1:0]  alu_operacion;
        logic        destino_reg;
        logic [31:0] dr1;
        logic [31:0] dr2;
        logic [31:0] ext;
        logic [31:0] pc_plus4;
        logic [31:0] jump_address;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        string  nombre;
        instr_t en_ex;
        instr_t en_id;
        logic   vac;
        logic   exp_pc;
        logic   exp_val;
    } vec_t;

    logic clk;
    logic rst_n;
    registro_id_ex_if bus ();
`ifdef CONTADORES_RENDIMIENTO_EN
    logic [31:0] cuenta_burbujas;
    logic [31:0] cuenta_vaciados;
`endif

    registro_id_ex #(
        .ANCHO_DATO (32),
        .ANCHO_REG  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CONTADORES_RENDIMIENTO_EN
        ,
        .cuenta_burbujas (cuenta_burbujas),
        .cuenta_vaciados (cuenta_vaciados)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // current stimulus
    instr_t cur_id;
    logic   cur_val, cur_vac, cur_det;

    // reference model: what EX should hold
    instr_t      m_ex;
    logic        m_val;
    logic [4:0]  m_dest;
    logic        m_bub;
    int unsigned m_cb, m_cv;

    function automatic logic [8:0] ctrl_of(instr_t x);
        return {x.salto, x.branch, x.mem_leer, x.mem_a_reg, x.mem_escribir,
                x.alu_fuente, x.reg_escribir, x.alu_operacion};
    endfunction

    function automatic instr_t sin_ctrl(instr_t x);
        instr_t y = x;
        y.salto = 0; y.branch = 0; y.mem_leer = 0; y.mem_a_reg = 0;
        y.mem_escribir = 0; y.alu_fuente = 0; y.reg_escribir = 0; y.alu_operacion = 2'b00;
        return y;
    endfunction

    function automatic instr_t dut_ex();
        instr_t x;
        x.salto = bus.salto_ex; x.branch = bus.branch_ex; x.mem_leer = bus.mem_leer_ex;
        x.mem_a_reg = bus.mem_a_reg_ex; x.mem_escribir = bus.mem_escribir_ex;
        x.alu_fuente = bus.alu_fuente_ex; x.reg_escribir = bus.reg_escribir_ex;
        x.alu_operacion = bus.alu_operacion_ex; x.destino_reg = bus.destino_reg_ex;
        x.dr1 = bus.dr1_ex; x.dr2 = bus.dr2_ex; x.ext = bus.ext_ex;
        x.pc_plus4 = bus.pc_plus4_ex; x.jump_address = bus.jump_address_ex;
        x.funct = bus.funct_ex; x.rs = bus.rs_ex; x.rt = bus.rt_ex; x.rd = bus.rd_ex;
        return x;
    endfunction

    // Model hazard: a valid load in EX targeting a non-zero register that ID reads
    function automatic logic m_riesgo();
        logic lee_rt = !cur_id.alu_fuente || cur_id.mem_escribir || cur_id.branch;
        if (!(m_val && m_ex.mem_leer && cur_val)) return 1'b0;
        if (m_dest == 5'd0) return 1'b0;
        return (m_dest == cur_id.rs) || (lee_rt && m_dest == cur_id.rt);
    endfunction

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    task automatic m_reset();
        m_ex = '0; m_val = 0; m_dest = '0; m_bub = 0; m_cb = 0; m_cv = 0;
    endtask

    task automatic apply(input instr_t x, input logic v, input logic vac, input logic det);
        cur_id = x; cur_val = v; cur_vac = vac; cur_det = det;
        bus.salto_id = x.salto; bus.branch_id = x.branch; bus.mem_leer_id = x.mem_leer;
        bus.mem_a_reg_id = x.mem_a_reg; bus.mem_escribir_id = x.mem_escribir;
        bus.alu_fuente_id = x.alu_fuente; bus.reg_escribir_id = x.reg_escribir;
        bus.alu_operacion_id = x.alu_operacion; bus.destino_reg_id = x.destino_reg;
        bus.dr1_id = x.dr1; bus.dr2_id = x.dr2; bus.ext_id = x.ext;
        bus.pc_plus4_id = x.pc_plus4; bus.jump_address_id = x.jump_address;
        bus.funct_id = x.funct; bus.rs_id = x.rs; bus.rt_id = x.rt; bus.rd_id = x.rd;
        bus.valido_id = v; bus.vaciar = vac; bus.detener = det;
    endtask

    // One clock: model decides from the rules, then DUT is sampled 1 time unit after the edge
    task automatic step();
        instr_t     n_ex  = m_ex;
        logic       n_val = m_val;
        logic [4:0] n_dest = m_dest;
        logic       n_bub = m_bub;
        if (cur_vac || (!cur_det && m_riesgo())) begin
            n_ex = sin_ctrl(cur_id); n_val = 0; n_bub = 1;
            if (cur_vac) m_cv++; else m_cb++;
        end else if (!cur_det) begin
            n_ex = cur_id; n_val = cur_val; n_bub = 0;
            n_dest = cur_id.destino_reg ? cur_id.rd : cur_id.rt;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_ex = n_ex; m_val = n_val; m_dest = n_dest; m_bub = n_bub;
        end
    endtask

    task automatic compare_all(input string n);
        instr_t a = dut_ex();
        chk({n, ".pc_escribir"}, 256'(bus.pc_escribir), 256'(!(m_riesgo() && !cur_vac)));
        chk({n, ".ifid_escribir"}, 256'(bus.ifid_escribir), 256'(!(m_riesgo() && !cur_vac)));
        chk({n, ".valido_ex"}, 256'(bus.valido_ex), 256'(m_val));
        chk({n, ".control_ex"}, 256'(ctrl_of(a)), 256'(ctrl_of(m_ex)));
        if (!m_bub) begin
            chk({n, ".datos_ex"}, 256'(sin_ctrl(a)), 256'(sin_ctrl(m_ex)));
            chk({n, ".reg_dest_ex"}, 256'(bus.reg_dest_ex), 256'(m_dest));
        end
`ifdef CONTADORES_RENDIMIENTO_EN
        chk({n, ".cuenta_burbujas"}, 256'(cuenta_burbujas), 256'(m_cb));
        chk({n, ".cuenta_vaciados"}, 256'(cuenta_vaciados), 256'(m_cv));
`endif
    endtask

    function automatic instr_t datos_aleatorios();
        instr_t x = '0;
        x.dr1 = $urandom; x.dr2 = $urandom; x.ext = $urandom;
        x.pc_plus4 = $urandom; x.jump_address = $urandom;
        return x;
    endfunction

    function automatic instr_t lw(input logic [4:0] rt, input logic [4:0] rs);
        instr_t x = datos_aleatorios();
        x.mem_leer = 1; x.mem_a_reg = 1; x.alu_fuente = 1; x.reg_escribir = 1;
        x.alu_operacion = 2'b00; x.rs = rs; x.rt = rt; x.rd = 5'(($urandom % 32));
        x.funct = 6'($urandom % 64);
        return x;
    endfunction

    function automatic instr_t add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = datos_aleatorios();
        x.reg_escribir = 1; x.destino_reg = 1; x.alu_operacion = 2'b10;
        x.funct = 6'h20; x.rs = rs; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    function automatic instr_t sw(input logic [4:0] rt, input logic [4:0] rs);
        instr_t x = datos_aleatorios();
        x.mem_escribir = 1; x.alu_fuente = 1; x.alu_operacion = 2'b00;
        x.rs = rs; x.rt = rt; x.ext = 32'd4;
        return x;
    endfunction

    function automatic instr_t addi(input logic [4:0] rt, input logic [4:0] rs);
        instr_t x = datos_aleatorios();
        x.alu_fuente = 1; x.reg_escribir = 1; x.alu_operacion = 2'b00;
        x.rs = rs; x.rt = rt; x.ext = 32'd1;
        return x;
    endfunction

    function automatic instr_t aleatoria();
        instr_t x = datos_aleatorios();
        x.salto = 1'($urandom % 8 == 0);
        x.branch = 1'($urandom % 6 == 0);
        x.mem_leer = 1'($urandom % 2);
        x.mem_a_reg = 1'($urandom % 2);
        x.mem_escribir = 1'($urandom % 4 == 0);
        x.alu_fuente = 1'($urandom % 2);
        x.reg_escribir = 1'($urandom % 2);
        x.alu_operacion = 2'($urandom % 3);
        x.destino_reg = 1'($urandom % 2);
        x.funct = 6'($urandom % 64);
        x.rs = 5'($urandom_range(0, 3));
        x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 3));
        return x;
    endfunction

    vec_t   tabla[7];
    instr_t nop;

    initial begin
        nop = '0;
        tabla[0] = '{"lw_rs",        lw(8, 1),  add(9, 8, 3),  1'b0, 1'b0, 1'b0};
        tabla[1] = '{"lw_sw_rt",     lw(5, 1),  sw(5, 2),      1'b0, 1'b0, 1'b0};
        tabla[2] = '{"lw_addi_rs",   lw(5, 1),  addi(7, 5),    1'b0, 1'b0, 1'b0};
        tabla[3] = '{"lw_addi_rt",   lw(5, 1),  addi(5, 2),    1'b0, 1'b1, 1'b1};
        tabla[4] = '{"lw_r0",        lw(0, 1),  add(1, 0, 0),  1'b0, 1'b1, 1'b1};
        tabla[5] = '{"flush_riesgo", lw(8, 1),  add(9, 8, 3),  1'b1, 1'b1, 1'b0};
        tabla[6] = '{"no_load",      add(8, 1, 2), add(9, 8, 3), 1'b0, 1'b1, 1'b1};

        // Reset, checked mid-cycle with no clock edge needed
        rst_n = 1'b1;
        apply(add(3, 1, 2), 1, 0, 0);
        #2 rst_n = 1'b0;
        m_reset();
        #1 compare_all("reset");
        chk("reset.pc_escribir_1", 256'(bus.pc_escribir), 256'(1));
        #9 rst_n = 1'b1;

        // Directed hazard table
        for (int unsigned i = 0; i < 7; i++) begin
            apply(nop, 0, 0, 0);                    step(); compare_all({tabla[i].nombre, ".prep"});
            apply(tabla[i].en_ex, 1, 0, 0);         step(); compare_all({tabla[i].nombre, ".ex"});
            apply(tabla[i].en_id, 1, tabla[i].vac, 0);
            #1;
            chk({tabla[i].nombre, ".pc_tabla"}, 256'(bus.pc_escribir), 256'(tabla[i].exp_pc));
            compare_all({tabla[i].nombre, ".id"});
            step();
            chk({tabla[i].nombre, ".valido_tabla"}, 256'(bus.valido_ex), 256'(tabla[i].exp_val));
            compare_all({tabla[i].nombre, ".tras"});
            apply(tabla[i].en_id, 1, 0, 0);         step(); compare_all({tabla[i].nombre, ".sig"});
        end

        // External stall combined with a pending hazard: hold wins, then bubble, then capture
        apply(lw(8, 1), 1, 0, 0); step(); compare_all("stall.ex");
        apply(add(9, 8, 3), 1, 0, 1);
        #1 chk("stall.pc_congelado", 256'(bus.pc_escribir), 256'(0));
        for (int unsigned k = 0; k < 3; k++) begin
            step(); compare_all("stall.hold");
            apply(aleatoria(), 1, 0, 1);
        end
        apply(add(9, 8, 3), 1, 0, 0); step(); compare_all("stall.burbuja");
        chk("stall.burbuja_valido", 256'(bus.valido_ex), 256'(0));
        step(); compare_all("stall.captura");
        chk("stall.rs_ex", 256'(bus.rs_ex), 256'(8));

        // Reset asserted while a bubble is pending, then normal capture
        apply(lw(8, 1), 1, 0, 0); step();
        apply(add(9, 8, 3), 1, 0, 0);
        #1 rst_n = 1'b0;
        m_reset();
        #1 compare_all("reset_burbuja");
        #1 rst_n = 1'b1;
        step(); compare_all("reset_captura");
        chk("reset_captura.valido", 256'(bus.valido_ex), 256'(1));

        // Randomized traffic
        for (int unsigned c = 0; c < 600; c++) begin
            apply(aleatoria(), 1'($urandom % 5 != 0), 1'($urandom % 10 == 0), 1'($urandom % 7 == 0));
            #1 compare_all("rnd.pre");
            step(); compare_all("rnd.post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/registro_id_ex.md
Name: registro_id_ex

Overview:
ID/EX pipeline register that consumes the decode stage's control and data outputs and presents them to execute one cycle later. Detects load-use hazards between the instruction in EX and the one in ID. On a hazard it freezes PC and IF/ID and inserts a bubble. Also handles flush on branch/jump redirect and an external whole-pipeline stall.

Parameters:
ANCHO_DATO, 32, datapath width
ANCHO_REG, 5, register index width

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
salto_id, branch_id, mem_leer_id, mem_a_reg_id, mem_escribir_id, alu_fuente_id, reg_escribir_id, destino_reg_id  input  1 each  decoded control from ID
alu_operacion_id  input  2  ALU op class from ID
dr1_id, dr2_id, ext_id, pc_plus4_id, jump_address_id  input  ANCHO_DATO each  register reads, sign-extended immediate, PC+4, jump target
funct_id  input  6  instr[5:0]
rs_id, rt_id, rd_id  input  ANCHO_REG each  instr[25:21], [20:16], [15:11]
valido_id  input  1  ID holds a real instruction
vaciar  input  1  flush: redirect taken, kill the ID instruction
detener  input  1  external stall: hold everything
*_ex (one per *_id input above, same widths)  output  registered copies
valido_ex  output  1  EX holds a real instruction
reg_dest_ex  output  ANCHO_REG  destino_reg ? rd : rt, resolved at capture
pc_escribir  output  1  0 = freeze PC
ifid_escribir  output  1  0 = freeze IF/ID

Behaviour:
- Reset, asynchronous on rst_n low: all *_ex outputs, reg_dest_ex and valido_ex go to 0. pc_escribir and ifid_escribir are combinational and read 1 with valido_ex=0.
- usa_rt = !alu_fuente_id | mem_escribir_id | branch_id.
- riesgo is combinational and requires all of:
  - valido_ex & mem_leer_ex & valido_id
  - reg_dest_ex != 0
  - (reg_dest_ex == rs_id) | (usa_rt & reg_dest_ex == rt_id)
- pc_escribir = ifid_escribir = !(riesgo & !vaciar). A flush overrides a hazard freeze.
- Per rising clk edge, priority order:
  1. vaciar: control outputs (salto, branch, mem_leer, mem_a_reg, mem_escribir, alu_fuente, reg_escribir, alu_operacion) cleared to 0; valido_ex=0; data fields captured from inputs.
  2. detener: every register holds, including valido_ex.
  3. riesgo: bubble, identical to the vaciar action.
  4. else: all fields captured; valido_ex = valido_id; reg_dest_ex computed from destino_reg_id.
- Latency: exactly 1 cycle from ID inputs to *_ex outputs.
- A bubble's data fields carry no meaning. Checkers compare only control outputs and valido_ex on bubbles.
- Hazard duration: one cycle per load-use pair. After the bubble, valido_ex=0, so riesgo drops and the held ID instruction is captured on the next edge.
- Register 0 never triggers a hazard.
- detener and riesgo together: hold wins; the freeze persists until detener releases.
- rst_n asserted mid-stall or mid-bubble clears state immediately; the first edge after release performs a normal capture.

Optional Feature:
- Macro: CONTADORES_RENDIMIENTO_EN.
- When defined, adds outputs cuenta_burbujas [31:0] and cuenta_vaciados [31:0].
  - cuenta_burbujas increments on each edge where a riesgo bubble is inserted.
  - cuenta_vaciados increments on each edge where vaciar acts.
  - Counters do not increment while detener is high, except that vaciar still counts because it has priority.
  - Counters wrap at 2^32 and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package pkg_segmentacion holds:
  - ANCHO_DATO and ANCHO_REG
  - the ALU op encodings (00 mem, 01 branch, 10 R-type)
  - a struct/typedef bundling the ID/EX control bits, so bubbles clear one field
- One natural sub-module: deteccion_riesgos. It is purely combinational: riesgo, pc_escribir, ifid_escribir.

Test Plan:
1. Reset: rst_n=0 mid-cycle → all *_ex=0, valido_ex=0, pc_escribir=1, without waiting for a clock edge.
2. Load-use on rs: EX = lw $8 (mem_leer=1, reg_dest=8); ID = add $9,$8,$3 → riesgo=1, pc_escribir=0 for one cycle, next valido_ex=0 with controls 0, then add captured with rs_ex=8.
3. Load-use on rt via sw: EX = lw $5; ID = sw $5,4($2) (mem_escribir=1) → one bubble. ID = addi $7,$5,1 (alu_fuente=1, rt=7, rs=5) also stalls via rs. ID = addi $5,$2,1 does not stall.
4. Register zero: EX = lw $0; ID = add $1,$0,$0 → no stall; capture on the next edge.
5. Flush plus hazard: vaciar=1 while riesgo=1 → pc_escribir=1; next edge valido_ex=0, controls 0; cuenta_vaciados+1, cuenta_burbujas unchanged (macro on).
6. External stall: detener=1 for 3 cycles with changing inputs → *_ex unchanged throughout; capture resumes on the first edge after release.
